md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy duration of multiply operations in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy duration of divide operations in cycles.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: a request to issue op this cycle.
REQ-006 SHALL have port op, input, 3: operation select.
- 000 mult; 001 multu; 010 div; 011 divu.
- 100 mthi; 101 mtlo; 110 madd; 111 maddu.
REQ-007 SHALL have port A, input, 32: operand rs (dividend/multiplicand; source of mthi/mtlo).
REQ-008 SHALL have port B, input, 32: operand rt (divisor/multiplier).
REQ-009 SHALL have port busy, output, 1: the unit is executing a multicycle operation.
REQ-010 SHALL have port HI, output, 32: the architectural HI register, consumed by the HI/LO read-select mux.
REQ-011 SHALL have port LO, output, 32: the architectural LO register.

Function
REQ-012 SHALL accept start only when busy=0; start while busy=1 SHALL be ignored entirely.
REQ-013 SHALL implement states IDLE, MULT and DIV.
- IDLE->MULT on accepted mult/multu/madd/maddu.
- IDLE->DIV on accepted div/divu.
- MULT/DIV->IDLE when the cycle counter expires.
REQ-014 SHALL, on a start accepted at edge k, capture the operands and drive busy=1 from after edge k until edge k+N, where N is MULT_CYCLES or DIV_CYCLES; busy SHALL be 0 after edge k+N.
REQ-015 SHALL update HI/LO at edge k+N only; HI/LO SHALL hold their old values while busy.
REQ-016 SHALL compute mult as a signed 32x32->64 product and multu as unsigned; {HI,LO} SHALL equal the product.
REQ-017 SHALL compute div/divu with LO=quotient and HI=remainder; signed quotient truncates toward zero and the remainder takes the sign of A.
REQ-018 SHALL, for divide by zero (B=0), produce LO=32'hFFFFFFFF and HI=A, and still hold busy for DIV_CYCLES.
REQ-019 SHALL, for signed 32'h80000000 / 32'hFFFFFFFF, produce LO=32'h80000000 and HI=0.
REQ-020 SHALL, for mthi/mtlo with busy=0, write A into HI/LO at that edge without asserting busy; the other register SHALL be unchanged.
REQ-021 SHALL use a 4-bit down-counter loaded with N-1 on acceptance; N SHALL be in the range 1..16.

Reset
REQ-022 SHALL, on reset=1, immediately force HI=0, LO=0, busy=0, state=IDLE and counter=0, regardless of clk.
REQ-023 SHALL treat reset during MULT/DIV as an abort: the pending result is discarded and HI/LO read 0.
REQ-024 SHALL accept a start on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL, with MDU_MADD_EN defined, implement madd/maddu as {HI,LO} += signed/unsigned A*B (mod 2^64), busy for MULT_CYCLES.
REQ-026 SHALL, without MDU_MADD_EN, treat op 110/111 as a no-op: no busy, and HI/LO unchanged.

Structure
REQ-027 SHALL take op encodings, state encodings and the MULT_CYCLES/DIV_CYCLES defaults from shared package md_pkg.
REQ-028 SHALL place signed/unsigned quotient/remainder generation, including the REQ-018/REQ-019 special cases, in sub-module md_div_core; the state machine, counter and HI/LO registers stay in md_unit.

Verification
REQ-029 SHALL verify mult with A=32'hFFFFFFFE (-2), B=3: busy is high for exactly 5 cycles, then HI=32'hFFFFFFFF and LO=32'hFFFFFFFA; multu with the same operands gives HI=2, LO=32'hFFFFFFFA.
REQ-030 SHALL verify div with A=-7, B=2: after 10 busy cycles LO=32'hFFFFFFFD (-3) and HI=32'hFFFFFFFF (-1); divu with A=7, B=2 gives LO=3, HI=1.
REQ-031 SHALL verify divu with A=32'h1234, B=0: LO=32'hFFFFFFFF and HI=32'h1234 after 10 cycles.
REQ-032 SHALL verify that a second start (mtlo, A=5) issued mid-mult is ignored: LO equals the product result, not 5.
REQ-033 SHALL verify reset asserted mid-div, asynchronously between edges: busy drops immediately, HI=LO=0, and a subsequent mthi A=9 gives HI=9 with no busy.
REQ-034 SHALL verify, with MDU_MADD_EN, HI=0, LO=32'hFFFFFFFF followed by maddu A=1, B=1: result HI=1, LO=0; without the macro, HI/LO are unchanged and busy stays 0.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg -- shared definitions for the multiply/divide unit.
//   * op encodings (md_op_e) and FSM state encodings (md_state_e)
//   * default busy durations for multiply and divide
//   * mul64: 32x32->64 product with selectable signedness
package md_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;   // down-counter width, N in 1..16

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MADDU = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // Sign- or zero-extend both operands to 64 bits; the low 64 bits of the
    // product are then the exact signed/unsigned 64-bit result.
    function automatic logic [63:0] mul64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        bx = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ax * bx;
    endfunction

endpackage

// File: rtl/md_div_core.sv
// md_div_core -- combinational quotient/remainder generator.
//   a, b      : dividend / divisor
//   is_signed : 1 = signed division (truncate toward zero, rem takes sign of a)
//   quot, rem : results
// Divide by zero yields quot = all ones, rem = a. The signed overflow case
// 0x80000000 / -1 yields quot = 0x80000000, rem = 0.
module md_div_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    always_comb begin
        quot = '0;
        rem  = '0;
        if (b == 32'h0) begin
            quot = 32'hFFFF_FFFF;
            rem  = a;
        end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            // Quotient +2^31 is not representable; wraps to 0x80000000.
            quot = 32'h8000_0000;
            rem  = 32'h0;
        end else if (is_signed) begin
            quot = $unsigned($signed(a) / $signed(b));
            rem  = $unsigned($signed(a) % $signed(b));
        end else begin
            quot = a / b;
            rem  = a % b;
        end
    end

endmodule

// File: rtl/md_unit.sv
// md_unit -- multicycle multiply/divide unit with architectural HI/LO.
//   clk, reset : clock, asynchronous active-high reset
//   start, op  : issue request and operation select (ignored while busy)
//   A, B       : operands (rs, rt); A is the source for mthi/mtlo
//   busy       : a multiply/divide is in flight
//   HI, LO     : architectural result registers
// Optional feature: define MDU_MADD_EN to enable madd/maddu
// ({HI,LO} += A*B). Without it, ops 110/111 are no-ops.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // Counter is loaded with N-1; the op completes on the edge where it is 0,
    // giving exactly N busy cycles.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_q, b_q;
    logic             sgn_q;
`ifdef MDU_MADD_EN
    logic             acc_q;
`endif

    logic        go_mult, go_div, wr_hi, wr_lo, done;
    logic [63:0] mul_res;
    logic [31:0] div_quot, div_rem;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (go_mult)     state_nxt = ST_MULT;
                else if (go_div) state_nxt = ST_DIV;
            end
            ST_MULT, ST_DIV: begin
                if (done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode; requests are only decoded in IDLE, so a start
    // while busy has no effect at all.
    always_comb begin
        busy    = (state != ST_IDLE);
        done    = busy && (cnt == '0);
        go_mult = 1'b0;
        go_div  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        if (state == ST_IDLE && start) begin
            case (md_op_e'(op))
                OP_MULT, OP_MULTU: go_mult = 1'b1;
                OP_DIV,  OP_DIVU:  go_div  = 1'b1;
                OP_MTHI:           wr_hi   = 1'b1;
                OP_MTLO:           wr_lo   = 1'b1;
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU: go_mult = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Result datapath works from the captured operands so A/B may change
    // while the unit is busy.
`ifdef MDU_MADD_EN
    assign mul_res = acc_q ? ({HI, LO} + mul64(a_q, b_q, sgn_q))
                           : mul64(a_q, b_q, sgn_q);
`else
    assign mul_res = mul64(a_q, b_q, sgn_q);
`endif

    md_div_core u_div (
        .a         (a_q),
        .b         (b_q),
        .is_signed (sgn_q),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    // Counter, operand capture and HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q <= 1'b0;
`endif
            HI    <= '0;
            LO    <= '0;
        end else begin
            if (go_mult || go_div) begin
                cnt   <= go_mult ? MULT_LOAD : DIV_LOAD;
                a_q   <= A;
                b_q   <= B;
                sgn_q <= ~op[0];   // even encodings are the signed variants
`ifdef MDU_MADD_EN
                acc_q <= op[2];
`endif
            end else if (busy && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (wr_hi) HI <= A;
            if (wr_lo) LO <= A;

            if (done) begin
                if (state == ST_MULT) {HI, LO} <= mul_res;
                else                  {HI, LO} <= {div_rem, div_quot};
            end
        end
    end

endmodule
